hazard_forward_ctrl: RTL and testbench

//  Combined hazard-detection, forwarding and flush controller for the 5-stage MIPS pipeline.

---
 rtl/hazard_forward_ctrl_if.sv | 71 +++++++
 rtl/hazard_forward_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_forward_ctrl_if
//   Bundles every pipeline-side signal of the hazard/forward/flush controller.
//   Signals keep the pipeline-register names they mirror (id_*, ex_*, mem_*,
//   wb_*), so the wiring reads like the datapath diagram.
//
//   There is no valid/ready handshake here. Every input is level-sampled each
//   cycle from the pipeline registers. The controls are combinational on those
//   inputs and the controller state. The event counters change only on a
//   rising clock edge.
//
//   Modports
//     master : pipeline side. Drives the register fields, receives the controls.
//     slave  : the controller.
//   Parameters
//     REG_W  register-address width
//     CNT_W  event-counter width
// ---------------------------------------------------------------------------
interface hazard_forward_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    // Pipeline-register fields.
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memread;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regwrite;
    logic [REG_W-1:0] wb_rd;
    logic             wb_regwrite;
    logic             branch_taken;
    logic             cnt_clear;

    // Controller outputs.
    logic             pc_write;
    logic             ifid_write;
    logic             ctrl_bubble;
    logic             flush_ifid;
    logic             flush_idex;
    logic             flush_exmem;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic [CNT_W-1:0] stall_events;
    logic [CNT_W-1:0] flush_events;
    logic [1:0]       fsm_state;    // debug view of the controller FSM

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_rs, ex_rt, ex_rd, ex_memread,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output branch_taken, cnt_clear,
        input  pc_write, ifid_write, ctrl_bubble,
        input  flush_ifid, flush_idex, flush_exmem,
        input  forward_a, forward_b, stall_events, flush_events, fsm_state
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_rs, ex_rt, ex_rd, ex_memread,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  branch_taken, cnt_clear,
        output pc_write, ifid_write, ctrl_bubble,
        output flush_ifid, flush_idex, flush_exmem,
        output forward_a, forward_b, stall_events, flush_events, fsm_state
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_forward_ctrl
//   Combined hazard-detection, forwarding and flush controller for the 5-stage
//   MIPS pipeline. The branch is resolved in MEM.
//
//   Ports
//     clock  rising-edge clock
//     reset  synchronous, active-high
//     bus    hazard_forward_ctrl_if.slave
//            inputs : pipeline-register fields, branch_taken, cnt_clear
//            outputs: pc_write, ifid_write, ctrl_bubble, flush_*,
//                     forward_a/b, stall_events, flush_events, fsm_state
//
//   Parameters
//     REG_W       register-address width
//     LOAD_STALL  bubbles inserted per load-use hazard (>= 1)
//     CNT_W       width of the saturating event counters
//
//   Forwarding encoding: 00 = ID/EX, 10 = EX/MEM, 01 = MEM/WB.
//   EX/MEM wins over MEM/WB.
// ---------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter int REG_W      = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    hazard_forward_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // The stall counter holds the bubbles still owed after the first one.
    // The first bubble is issued from RUN.
    localparam int SCNT_W = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;
    localparam logic [SCNT_W-1:0] STALL_INIT = SCNT_W'(LOAD_STALL - 1);

    state_t             state;
    state_t             stateNext;
    logic [SCNT_W-1:0]  stallCnt;
    logic [SCNT_W-1:0]  stallCntNext;
    logic [CNT_W-1:0]   stallEv;
    logic [CNT_W-1:0]   flushEv;

    logic               loadUse;
    logic               pcWrite;
    logic               ifidWrite;
    logic               ctrlBubble;
    logic               flushAll;

    // True when a writing stage targets a non-zero register equal to src.
    function automatic logic hits(input logic regWrite,
                                  input logic [REG_W-1:0] dst,
                                  input logic [REG_W-1:0] src);
        return regWrite && (dst != '0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src);
        if (hits(bus.mem_regwrite, bus.mem_rd, src))
            return 2'b10;
        else if (hits(bus.wb_regwrite, bus.wb_rd, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        loadUse = bus.ex_memread && (bus.ex_rd != '0) &&
                  ((bus.id_use_rs && (bus.ex_rd == bus.id_rs)) ||
                   (bus.id_use_rt && (bus.ex_rd == bus.id_rt)));
    end

    // Next state and control outputs.
    always_comb begin
        stateNext    = state;
        stallCntNext = stallCnt;
        pcWrite      = 1'b1;
        ifidWrite    = 1'b1;
        ctrlBubble   = 1'b0;
        flushAll     = 1'b0;

        if (reset) begin
            pcWrite      = 1'b0;
            ifidWrite    = 1'b0;
            ctrlBubble   = 1'b1;
            stateNext    = RUN;
            stallCntNext = '0;
        end else if (bus.branch_taken) begin
            // A taken branch beats any pending or new load-use stall.
            // Fetch goes on down the new path, and the flushes clear the
            // wrong-path instructions.
            flushAll     = 1'b1;
            stateNext    = FLUSH;
            stallCntNext = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (loadUse) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        ctrlBubble = 1'b1;
                        if (LOAD_STALL > 1) begin
                            stateNext    = STALL;
                            stallCntNext = STALL_INIT;
                        end
                    end
                end
                STALL: begin
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    ctrlBubble = 1'b1;
                    if (stallCnt <= SCNT_W'(1)) begin
                        stateNext    = RUN;
                        stallCntNext = '0;
                    end else begin
                        stallCntNext = stallCnt - SCNT_W'(1);
                    end
                end
                FLUSH: begin
                    // ID/EX holds a bubble, so load-use is not checked here.
                    stateNext = RUN;
                end
                default: begin
                    stateNext    = RUN;
                    stallCntNext = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            stallCnt <= '0;
        end else begin
            state    <= stateNext;
            stallCnt <= stallCntNext;
        end
    end

    // Saturating event counters. A clear wins over an increment.
    always_ff @(posedge clock) begin
        if (reset || bus.cnt_clear) begin
            stallEv <= '0;
            flushEv <= '0;
        end else begin
            if (ctrlBubble && (stallEv != '1))
                stallEv <= stallEv + CNT_W'(1);
            if (flushAll && (flushEv != '1))
                flushEv <= flushEv + CNT_W'(1);
        end
    end

    always_comb begin
        bus.pc_write     = pcWrite;
        bus.ifid_write   = ifidWrite;
        bus.ctrl_bubble  = ctrlBubble;
        bus.flush_ifid   = flushAll;
        bus.flush_idex   = flushAll;
        bus.flush_exmem  = flushAll;
        bus.forward_a    = reset ? 2'b00 : fwdSel(bus.ex_rs);
        bus.forward_b    = reset ? 2'b00 : fwdSel(bus.ex_rt);
        bus.stall_events = stallEv;
        bus.flush_events = flushEv;
        bus.fsm_state    = state;
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_ctrl
//   Two controllers share one stimulus: A (LOAD_STALL=1, CNT_W=4) and
//   B (LOAD_STALL=3, CNT_W=8). A reference model tracks "bubbles still owed"
//   and "previous cycle flushed" for each controller. It predicts every
//   output on every cycle.
// ---------------------------------------------------------------------------
module tb_hazard_forward_ctrl;
    localparam int REG_W = 5;
    localparam int CNT_A = 4;
    localparam int CNT_B = 8;

    // Clock and reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    hazard_forward_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_A)) busA();
    hazard_forward_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_B)) busB();

    hazard_forward_ctrl #(.REG_W(REG_W), .LOAD_STALL(1), .CNT_W(CNT_A)) dutA (
        .clock(clock), .reset(reset), .bus(busA));
    hazard_forward_ctrl #(.REG_W(REG_W), .LOAD_STALL(3), .CNT_W(CNT_B)) dutB (
        .clock(clock), .reset(reset), .bus(busB));

    // Shared stimulus
    logic [REG_W-1:0] idRs, idRt, exRs, exRt, exRd, memRd, wbRd;
    logic idUseRs, idUseRt, exMemread, memRegwrite, wbRegwrite, branchTaken, cntClear;

    assign busA.id_rs = idRs;          assign busB.id_rs = idRs;
    assign busA.id_rt = idRt;          assign busB.id_rt = idRt;
    assign busA.id_use_rs = idUseRs;   assign busB.id_use_rs = idUseRs;
    assign busA.id_use_rt = idUseRt;   assign busB.id_use_rt = idUseRt;
    assign busA.ex_rs = exRs;          assign busB.ex_rs = exRs;
    assign busA.ex_rt = exRt;          assign busB.ex_rt = exRt;
    assign busA.ex_rd = exRd;          assign busB.ex_rd = exRd;
    assign busA.ex_memread = exMemread;     assign busB.ex_memread = exMemread;
    assign busA.mem_rd = memRd;             assign busB.mem_rd = memRd;
    assign busA.mem_regwrite = memRegwrite; assign busB.mem_regwrite = memRegwrite;
    assign busA.wb_rd = wbRd;               assign busB.wb_rd = wbRd;
    assign busA.wb_regwrite = wbRegwrite;   assign busB.wb_regwrite = wbRegwrite;
    assign busA.branch_taken = branchTaken; assign busB.branch_taken = branchTaken;
    assign busA.cnt_clear = cntClear;       assign busB.cnt_clear = cntClear;

    // Reference model state, indexed 0 = A, 1 = B
    int remaining[2];
    bit flushPrev[2];
    int stallEvM[2];
    int flushEvM[2];
    int loadStall[2] = '{1, 3};
    int cntMax[2]    = '{(1 << CNT_A) - 1, (1 << CNT_B) - 1};
    bit expPc[2], expIfid[2], expBubble[2], expFlush[2];
    int expFa, expFb;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit luRef();
        return exMemread && (exRd != 0) &&
               ((idUseRs && exRd == idRs) || (idUseRt && exRd == idRt));
    endfunction

    // Forwarding source: 2 = EX/MEM, 1 = MEM/WB, 0 = register file
    function automatic int fwdRef(input logic [REG_W-1:0] src);
        if (memRegwrite && memRd != 0 && memRd == src) return 2;
        if (wbRegwrite && wbRd != 0 && wbRd == src) return 1;
        return 0;
    endfunction

    task automatic evalModel(input int d);
        expPc[d] = 1; expIfid[d] = 1; expBubble[d] = 0; expFlush[d] = 0;
        if (reset) begin
            expPc[d] = 0; expIfid[d] = 0; expBubble[d] = 1;
        end else if (branchTaken) begin
            expFlush[d] = 1;
        end else if (remaining[d] > 0 || (!flushPrev[d] && luRef())) begin
            expPc[d] = 0; expIfid[d] = 0; expBubble[d] = 1;
        end
        expFa = reset ? 0 : fwdRef(exRs);
        expFb = reset ? 0 : fwdRef(exRt);
    endtask

    task automatic advance(input int d);
        if (reset) begin
            remaining[d] = 0; flushPrev[d] = 0; stallEvM[d] = 0; flushEvM[d] = 0;
        end else begin
            if (cntClear) begin
                stallEvM[d] = 0; flushEvM[d] = 0;
            end else begin
                if (expBubble[d] && stallEvM[d] < cntMax[d]) stallEvM[d]++;
                if (expFlush[d] && flushEvM[d] < cntMax[d]) flushEvM[d]++;
            end
            if (branchTaken) remaining[d] = 0;
            else if (remaining[d] > 0) remaining[d]--;
            else if (!flushPrev[d] && luRef()) remaining[d] = loadStall[d] - 1;
            flushPrev[d] = branchTaken;
        end
    endtask

    task automatic checkAll();
        chk("A_pc_write", busA.pc_write, expPc[0]);
        chk("A_ifid_write", busA.ifid_write, expIfid[0]);
        chk("A_ctrl_bubble", busA.ctrl_bubble, expBubble[0]);
        chk("A_flush_ifid", busA.flush_ifid, expFlush[0]);
        chk("A_flush_idex", busA.flush_idex, expFlush[0]);
        chk("A_flush_exmem", busA.flush_exmem, expFlush[0]);
        chk("A_forward_a", busA.forward_a, expFa);
        chk("A_forward_b", busA.forward_b, expFb);
        chk("A_stall_events", busA.stall_events, stallEvM[0]);
        chk("A_flush_events", busA.flush_events, flushEvM[0]);
        chk("B_pc_write", busB.pc_write, expPc[1]);
        chk("B_ifid_write", busB.ifid_write, expIfid[1]);
        chk("B_ctrl_bubble", busB.ctrl_bubble, expBubble[1]);
        chk("B_flush_ifid", busB.flush_ifid, expFlush[1]);
        chk("B_flush_idex", busB.flush_idex, expFlush[1]);
        chk("B_flush_exmem", busB.flush_exmem, expFlush[1]);
        chk("B_forward_a", busB.forward_a, expFa);
        chk("B_forward_b", busB.forward_b, expFb);
        chk("B_stall_events", busB.stall_events, stallEvM[1]);
        chk("B_flush_events", busB.flush_events, flushEvM[1]);
    endtask

    // Driver tasks
    task automatic idle();
        idRs = '0; idRt = '0; exRs = '0; exRt = '0; exRd = '0; memRd = '0; wbRd = '0;
        idUseRs = 0; idUseRt = 0; exMemread = 0; memRegwrite = 0; wbRegwrite = 0;
        branchTaken = 0; cntClear = 0;
    endtask

    // lw $2 in ID/EX, add $3,$2,$4 in IF/ID
    task automatic loadUse();
        exMemread = 1; exRd = 5'd2; idRs = 5'd2; idRt = 5'd4; idUseRs = 1; idUseRt = 1;
    endtask

    task automatic settle();
        @(negedge clock);
        evalModel(0);
        evalModel(1);
        checkAll();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        advance(0);
        advance(1);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clock);
        #1;
        advance(0);
        advance(1);

        // Outputs while reset is held
        step();
        step();
        reset = 0;
        step();

        // Single load-use, LOAD_STALL=1 on A
        loadUse();
        settle();
        chk("t1_A_bubble", busA.ctrl_bubble, 1);
        chk("t1_A_pc", busA.pc_write, 0);
        tick();
        idle();
        settle();
        chk("t1_A_stall_events", busA.stall_events, 1);
        chk("t1_A_pc_after", busA.pc_write, 1);
        tick();
        step();
        step();

        // Same hazard on B: exactly three bubbles
        cntClear = 1;
        step();
        cntClear = 0;
        loadUse();
        settle();
        chk("t2_B_bubble0", busB.ctrl_bubble, 1);
        tick();
        idle();
        for (int i = 1; i < 3; i++) begin
            settle();
            chk("t2_B_bubble", busB.ctrl_bubble, 1);
            tick();
        end
        settle();
        chk("t2_B_pc_after", busB.pc_write, 1);
        chk("t2_B_stall_events", busB.stall_events, 3);
        tick();

        // Forwarding priority and the zero register
        memRd = 5'd5; wbRd = 5'd5; memRegwrite = 1; wbRegwrite = 1; exRs = 5'd5;
        settle();
        chk("t3_fwd_a_exmem", busA.forward_a, 2'b10);
        tick();
        memRd = '0; wbRd = '0; exRt = '0;
        settle();
        chk("t3_fwd_b_zero", busA.forward_b, 2'b00);
        tick();
        idle();

        // Branch during the 2nd of 3 stall cycles on B
        loadUse();
        step();
        idle();
        branchTaken = 1;
        settle();
        chk("t4_B_flush_ifid", busB.flush_ifid, 1);
        chk("t4_B_flush_exmem", busB.flush_exmem, 1);
        chk("t4_B_pc", busB.pc_write, 1);
        tick();
        branchTaken = 0;
        loadUse();
        settle();
        chk("t4_B_no_bubble_in_flush", busB.ctrl_bubble, 0);
        tick();
        idle();
        step();

        // Saturation of A's stall counter, then clear
        reset = 1;
        step();
        reset = 0;
        loadUse();
        for (int i = 0; i < (1 << CNT_A) + 3; i++) step();
        settle();
        chk("t5_A_saturated", busA.stall_events, 4'hF);
        tick();
        cntClear = 1;
        step();
        cntClear = 0;
        idle();
        settle();
        chk("t5_A_cleared", busA.stall_events, 0);
        tick();

        // Reset in the middle of B's stall
        loadUse();
        step();
        idle();
        reset = 1;
        settle();
        chk("t6_B_pc_in_reset", busB.pc_write, 0);
        chk("t6_B_bubble_in_reset", busB.ctrl_bubble, 1);
        tick();
        reset = 0;
        settle();
        chk("t6_B_run_after", busB.pc_write, 1);
        chk("t6_B_events_after", busB.stall_events, 0);
        tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            idRs = REG_W'($urandom_range(0, 3));
            idRt = REG_W'($urandom_range(0, 3));
            exRs = REG_W'($urandom_range(0, 3));
            exRt = REG_W'($urandom_range(0, 3));
            exRd = REG_W'($urandom_range(0, 3));
            memRd = REG_W'($urandom_range(0, 3));
            wbRd = REG_W'($urandom_range(0, 3));
            idUseRs = 1'($urandom_range(0, 1));
            idUseRt = 1'($urandom_range(0, 1));
            exMemread = 1'($urandom_range(0, 1));
            memRegwrite = 1'($urandom_range(0, 1));
            wbRegwrite = 1'($urandom_range(0, 1));
            branchTaken = ($urandom_range(0, 9) == 0);
            cntClear = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 59) == 0);
            step();
        end
        reset = 0;
        idle();
        step();

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
